// File: rtl/twoof5_check_sched.sv
// twoof5_check_sched
// Shares one combinational two-out-of-five checker among N_REQ requesters.
// A round-robin arbiter picks a requester, its code word is registered onto
// the checker input, held for SETTLE_CYC cycles, and then the detect line is
// sampled. Each completed check produces a one-hot ACK, a pass/fail result
// and an update of that requester's saturating error counter.
module twoof5_check_sched #(
   parameter int N_REQ      = 4,
   parameter int SETTLE_CYC = 2,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic [N_REQ-1:0]             REQ,
   input  logic [5*N_REQ-1:0]           CODE_IN,
   output logic [N_REQ-1:0]             ACK,
   output logic                         RES_ERR,
   output logic [4:0]                   CHK_CODE,
   input  logic                         CHK_DET,
   output logic                         BUSY,
   input  logic                         CLR_CNT,
   output logic [ERR_CNT_W*N_REQ-1:0]   ERR_CNT
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'(SETTLE_CYC - 1);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       win_q, win_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [4:0]             code_q, code_d;
   logic [N_REQ-1:0]       ack_q, ack_d;
   logic                   res_q, res_d;
   logic                   busy_q, busy_d;
   logic [ERR_CNT_W-1:0]   errCnt_q [N_REQ];
   logic [ERR_CNT_W-1:0]   errCnt_d [N_REQ];

   logic                   anyReq;
   logic [IDX_W-1:0]       rrWin;

   // Round-robin pick: walk backwards so the first active requester at or after ptr wins.
   always_comb begin
      int idx;
      idx    = 0;
      anyReq = 1'b0;
      rrWin  = ptr_q;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % N_REQ;
         if (REQ[idx]) begin
            anyReq = 1'b1;
            rrWin  = IDX_W'(idx);
         end
      end
   end

   // Next-state logic: select, settle countdown, result capture and counter update.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      ack_d   = '0;
      res_d   = res_q;
      for (int i = 0; i < N_REQ; i++) begin
         errCnt_d[i] = errCnt_q[i];
      end

      case (state_q)
         IDLE: begin
            if (anyReq) begin
               win_d   = rrWin;
               code_d  = CODE_IN[5*rrWin +: 5];
               cnt_d   = CNT_INIT;
               ptr_d   = (rrWin == LAST_IDX) ? '0 : rrWin + IDX_W'(1);
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               res_d        = CHK_DET;
               ack_d[win_q] = 1'b1;
               if (CHK_DET && (errCnt_q[win_q] != CNT_MAX)) begin
                  errCnt_d[win_q] = errCnt_q[win_q] + ERR_CNT_W'(1);
               end
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (CLR_CNT) begin
         for (int i = 0; i < N_REQ; i++) begin
            errCnt_d[i] = '0;
         end
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
         code_q  <= 5'b00000;
         ack_q   <= '0;
         res_q   <= 1'b0;
         busy_q  <= 1'b0;
         for (int i = 0; i < N_REQ; i++) begin
            errCnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         ack_q   <= ack_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         for (int i = 0; i < N_REQ; i++) begin
            errCnt_q[i] <= errCnt_d[i];
         end
      end
   end

   // Pack the per-requester counters onto the flat output bus.
   always_comb begin
      ERR_CNT = '0;
      for (int i = 0; i < N_REQ; i++) begin
         ERR_CNT[ERR_CNT_W*i +: ERR_CNT_W] = errCnt_q[i];
      end
   end

   assign ACK      = ack_q;
   assign RES_ERR  = res_q;
   assign CHK_CODE = code_q;
   assign BUSY     = busy_q;

endmodule

// File: doc/twoof5_check_sched.md
# twoof5_check_sched

Round-robin scheduler that shares one combinational two-out-of-five code checker among `N_REQ` requesters. It arbitrates the requests, drives the winner's code word onto the checker input, waits a programmable settle time for the checker's propagation delay, then samples the detect line. It returns a per-requester acknowledge with the pass/fail result and keeps saturating per-requester error counters. It sits between the code-word producers and the checker instance in the code-validation path.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `SETTLE_CYC`, 2: cycles `CHK_CODE` is held stable before `CHK_DET` is sampled, minimum 1. Covers the checker's 10 ns delay.
- `ERR_CNT_W`, 8: width of each error counter.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `REQ`  in  `N_REQ`  per-requester request level.
- `CODE_IN`  in  `5*N_REQ`  requester i's code word at bits [5i+4:5i]. Held stable while `REQ[i]`=1.
- `ACK`  out  `N_REQ`  one-cycle completion pulse, one-hot.
- `RES_ERR`  out  1  result, valid while any `ACK` bit is high. 1 = invalid code word, 0 = valid.
- `CHK_CODE`  out  5  code word driven to the checker `CODE` input.
- `CHK_DET`  in  1  checker `DET` output. 0 = valid, 1 = error.
- `BUSY`  out  1  high whenever the state is not IDLE.
- `CLR_CNT`  in  1  synchronous clear of all error counters.
- `ERR_CNT`  out  `ERR_CNT_W*N_REQ`  requester i's error count at bits [W*i+W-1:W*i].

## Operation
- FSM states: IDLE, SETTLE, DONE.
- **IDLE:** if any `REQ` bit is high, select the winner by round robin.
  - Search starts at `ptr` and proceeds `ptr`, `ptr+1`, … mod `N_REQ`.
  - On the select edge: `win` <= winner index; `CHK_CODE` <= winner's code word; `cnt` <= `SETTLE_CYC-1`; `ptr` <= (winner+1) mod `N_REQ`; next state SETTLE.
  - With no request, the FSM stays in IDLE and `CHK_CODE` holds its last value.
- **SETTLE:** `CHK_CODE` is held constant.
  - While `cnt`≠0, decrement `cnt`.
  - When `cnt`=0: `RES_ERR` <= `CHK_DET`; `ACK[win]` <= 1; if `CHK_DET`=1, increment `ERR_CNT[win]`; next state DONE.
- **DONE:** `ACK` and `RES_ERR` are visible for this one cycle. On the next edge, `ACK` <= 0 and the FSM returns to IDLE.
  - `RES_ERR` holds its value until the next sample.
- **Requester rule:**
  - Hold `REQ` and `CODE_IN` stable until `ACK` is seen.
  - Deassert `REQ` on the edge that samples `ACK` if no further word is pending.
  - Keeping `REQ` high requests another check; round robin then favours the other requesters.
- **REQ dropped mid-transaction:** the transaction completes normally and `ACK` is still pulsed. `CODE_IN` changes after the select edge have no effect, because `CHK_CODE` is registered.
- **Error counters:** saturate at all-ones with no wrap.
  - `CLR_CNT` zeroes all counters on the next edge.
  - If `CLR_CNT` coincides with an increment, the clear wins and the counter becomes 0.
- **Reset (any state, including mid-transaction):** state=IDLE, `ptr`=0, `win`=0, `cnt`=0, `CHK_CODE`=5'b00000, `ACK`=0, `RES_ERR`=0, `BUSY`=0, all `ERR_CNT`=0. An aborted transaction produces no `ACK`.

## Timing
- Latency: the select edge is E0. `CHK_CODE` is valid from just after E0. `CHK_DET` is sampled at edge E0+`SETTLE_CYC`. `ACK` is high during the cycle between E0+`SETTLE_CYC` and E0+`SETTLE_CYC`+1.
- Throughput: one check per `SETTLE_CYC`+2 cycles under continuous requests.
- `CHK_CODE` is stable for at least `SETTLE_CYC` full cycles before sampling. With `SETTLE_CYC`=1, `CHK_DET` is sampled exactly one cycle after the select edge.
- `ACK`, `RES_ERR`, `BUSY`, `CHK_CODE` and `ERR_CNT` are all registered outputs.
- `CHK_DET` is treated as synchronous; the settle window guarantees it is stable when sampled.

## Test plan
Bench: `N_REQ`=4, `SETTLE_CYC`=2, `ERR_CNT_W`=4. The checker model drives `CHK_DET`=0 iff the code word has exactly two ones.

- **Single request:** `REQ`=4'b0001, code 5'b00011 -> `CHK_CODE`=00011 after E0; `ACK`=0001 at E0+2 with `RES_ERR`=0; `BUSY` high for 3 cycles; `ERR_CNT[0]`=0.
- **Round robin:** `REQ`=4'b1111 held, codes valid -> `ACK` order 0,1,2,3,0; one `ACK` every 4 cycles.
- **Errors and saturation:** requester 2 sends 5'b00111 seventeen times -> every `RES_ERR`=1; `ERR_CNT[2]` counts 1..15 then stays at 15.
- **Clear collision:** `CLR_CNT`=1 on the same edge as an error increment for requester 1 -> `ERR_CNT[1]`=0 afterwards.
- **Reset mid-operation:** `RST_N` pulsed low during SETTLE -> no `ACK`; all outputs at reset values; next request is served from `ptr`=0.
- **Drop and code change:** `REQ[3]` dropped and `CODE_IN[3]` changed to 5'b11111 one cycle after E0 (original code 5'b01100) -> `ACK`=1000 still issued with `RES_ERR`=0.
